// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared state type and default constants for period_meter.
// Holds default widths/timeouts and the averaging depth used with PERIOD_METER_AVG_EN.
package period_meter_pkg;

   localparam int CNT_W_DEF       = 25;
   localparam int TIMEOUT_CYC_DEF = 1000000;
   localparam int AVG_DEPTH       = 4;
   localparam int AVG_SHIFT       = 2;

   typedef enum logic {
      IDLE,
      MEAS
   } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-flop synchronizer plus history flop, emits rise/fall pulses.
// Ports: clkin clock, din async input, rise/fall one-cycle pulses.
module sync_edge_det (
   input  logic clkin,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic s1;
   logic s2;
   logic s3;

   // No reset: the chain keeps sampling during reset so that a level
   // held through reset never looks like an edge once reset drops.
   always_ff @(posedge clkin) begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
   end

   assign rise = s2 & ~s3;
   assign fall = ~s2 & s3;

endmodule

// File: rtl/period_meter.sv
// period_meter: measures period and high time of a slow square wave in clkin cycles.
// Ports: clkin, rst (sync, active-high), sig_in; period, high_time, valid, locked, timeout. Macro PERIOD_METER_AVG_EN enables 4-deep averaging.
module period_meter
   import period_meter_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic             clkin,
   input  logic             rst,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             valid,
   output logic             locked,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

   logic             rise;
   logic             fall;
   state_t           state;
   state_t           state_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_p1;
   logic [CNT_W-1:0] hi_cap;
   logic             meas_done;
   logic             tmo_hit;

   sync_edge_det u_sync (
      .clkin (clkin),
      .din   (sig_in),
      .rise  (rise),
      .fall  (fall)
   );

   assign cnt_p1    = cnt + 1'b1;
   assign meas_done = (state == MEAS) && rise;
   // A rise on the saturation cycle still counts as a measurement.
   assign tmo_hit   = (state == MEAS) && !rise && (cnt == CNT_MAX);

   always_ff @(posedge clkin) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (1'b1)
         (state == IDLE) && rise: state_n = MEAS;
         tmo_hit:                 state_n = IDLE;
         default:                 ;
      endcase
   end

   always_ff @(posedge clkin) begin
      if (rst)                 cnt <= '0;
      else if (rise)           cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt_p1;
   end

   always_ff @(posedge clkin) begin
      if (rst)                         hi_cap <= '0;
      else if ((state == MEAS) && fall) hi_cap <= cnt_p1;
   end

`ifdef PERIOD_METER_AVG_EN

   localparam logic [2:0] N_SAT  = 3'(AVG_DEPTH);
   localparam logic [2:0] N_FULL = 3'(AVG_DEPTH - 1);

   logic [CNT_W-1:0] p_hist [AVG_DEPTH];
   logic [CNT_W-1:0] h_hist [AVG_DEPTH];
   logic [CNT_W+1:0] p_sum;
   logic [CNT_W+1:0] h_sum;
   logic [CNT_W+1:0] p_sum_n;
   logic [CNT_W+1:0] h_sum_n;
   logic [2:0]       n_meas;

   // Running sums: add the newest sample, drop the one falling off the end.
   // Unfilled slots hold zero, so the sum is correct while filling.
   assign p_sum_n = p_sum + {2'b00, cnt_p1}
                  - {2'b00, p_hist[AVG_DEPTH-1]};
   assign h_sum_n = h_sum + {2'b00, hi_cap}
                  - {2'b00, h_hist[AVG_DEPTH-1]};

   always_ff @(posedge clkin) begin
      if (rst) begin
         for (int i = 0; i < AVG_DEPTH; i++) begin
            p_hist[i] <= '0;
            h_hist[i] <= '0;
         end
         p_sum     <= '0;
         h_sum     <= '0;
         n_meas    <= '0;
         period    <= '0;
         high_time <= '0;
         valid     <= 1'b0;
         locked    <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (meas_done) begin
            for (int i = AVG_DEPTH - 1; i > 0; i--) begin
               p_hist[i] <= p_hist[i-1];
               h_hist[i] <= h_hist[i-1];
            end
            p_hist[0] <= cnt_p1;
            h_hist[0] <= hi_cap;
            p_sum     <= p_sum_n;
            h_sum     <= h_sum_n;
            if (n_meas != N_SAT) n_meas <= n_meas + 1'b1;
            if (n_meas >= N_FULL) begin
               period    <= p_sum_n[CNT_W+1:AVG_SHIFT];
               high_time <= h_sum_n[CNT_W+1:AVG_SHIFT];
               valid     <= 1'b1;
               locked    <= 1'b1;
               timeout   <= 1'b0;
            end
         end else if (tmo_hit) begin
            for (int i = 0; i < AVG_DEPTH; i++) begin
               p_hist[i] <= '0;
               h_hist[i] <= '0;
            end
            p_sum   <= '0;
            h_sum   <= '0;
            n_meas  <= '0;
            locked  <= 1'b0;
            timeout <= 1'b1;
         end
      end
   end

`else

   always_ff @(posedge clkin) begin
      if (rst) begin
         period    <= '0;
         high_time <= '0;
         valid     <= 1'b0;
         locked    <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (meas_done) begin
            period    <= cnt_p1;
            high_time <= hi_cap;
            valid     <= 1'b1;
            locked    <= 1'b1;
            timeout   <= 1'b0;
         end else if (tmo_hit) begin
            locked  <= 1'b0;
            timeout <= 1'b1;
         end
      end
   end

`endif

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: scoreboard bench for period_meter against an edge-timing model.
// Model derives period/high time from the driven waveform's edge times.
module tb_period_meter;

   localparam int CW  = 16;
   localparam int TMO = 100;

   logic          clkin  = 1'b0;
   logic          rst    = 1'b1;
   logic          sig_in = 1'b0;
   logic [CW-1:0] period;
   logic [CW-1:0] high_time;
   logic          valid;
   logic          locked;
   logic          timeout;

   period_meter #(
      .CNT_W       (CW),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clkin     (clkin),
      .rst       (rst),
      .sig_in    (sig_in),
      .period    (period),
      .high_time (high_time),
      .valid     (valid),
      .locked    (locked),
      .timeout   (timeout)
   );

   always #5 clkin = ~clkin;

   typedef struct {
      int p;
      int h;
   } meas_t;

   meas_t exp_q[$];
   meas_t last_exp;
   int    n_vec = 0;
   int    n_err = 0;
   int    t_drv = 0;
   int    obs_p = 0;
   int    obs_h = 0;
   bit    m_act = 0;
   int    m_prev = 0;
   int    m_fall = 0;
   int    hp[$];
   int    hh[$];

   task automatic chk(string nm, int act, int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", nm, act, req);
      end
   endtask

   task automatic chk_zero(string nm);
      chk({nm, " period"}, period, 0);
      chk({nm, " high_time"}, high_time, 0);
      chk({nm, " valid"}, valid, 0);
      chk({nm, " locked"}, locked, 0);
      chk({nm, " timeout"}, timeout, 0);
   endtask

   function automatic void m_reset();
      m_act = 0;
      hp.delete();
      hh.delete();
   endfunction

   // A rise closes a measurement if the previous rise is within the
   // timeout window; otherwise it only starts a fresh one.
   function automatic void on_rise(int t);
      meas_t e;
      if (m_act && (t - m_prev) <= TMO) begin
         e.p = t - m_prev;
         e.h = m_fall - m_prev;
`ifdef PERIOD_METER_AVG_EN
         hp.push_back(e.p);
         hh.push_back(e.h);
         if (hp.size() > 4) begin
            void'(hp.pop_front());
            void'(hh.pop_front());
         end
         if (hp.size() == 4) begin
            e.p = (hp[0] + hp[1] + hp[2] + hp[3]) / 4;
            e.h = (hh[0] + hh[1] + hh[2] + hh[3]) / 4;
            exp_q.push_back(e);
            last_exp = e;
         end
`else
         exp_q.push_back(e);
         last_exp = e;
`endif
      end else begin
         hp.delete();
         hh.delete();
      end
      m_act  = 1;
      m_prev = t;
   endfunction

   task automatic step();
      @(negedge clkin);
      t_drv++;
   endtask

   task automatic set_sig(bit v);
      if (!rst) begin
         if (v && !sig_in)      on_rise(t_drv);
         else if (!v && sig_in) m_fall = t_drv;
      end
      sig_in = v;
   endtask

   task automatic wave(int hi, int lo, int n);
      repeat (n) begin
         set_sig(1'b1);
         repeat (hi) step();
         set_sig(1'b0);
         repeat (lo) step();
      end
   endtask

   initial begin
      meas_t e;
      forever begin
         @(negedge clkin);
         if (!rst && valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected valid", 1, 0);
            end else begin
               e = exp_q.pop_front();
               obs_p = period;
               obs_h = high_time;
               chk("period", period, e.p);
               chk("high_time", high_time, e.h);
               chk("locked on valid", locked, 1);
               chk("timeout on valid", timeout, 0);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      repeat (3) begin
         sig_in = ~sig_in;
         step();
      end
      sig_in = 1'b0;
      repeat (3) step();
      chk_zero("in reset");
      rst = 1'b0;
      m_reset();
      repeat (20) step();
      chk_zero("idle after reset");

      wave(5, 5, 6);
      wave(3, 7, 4);
      chk("duty change period", obs_p, 10);
      chk("duty change high", obs_h, 3);

      while (t_drv < m_prev + 95) step();
      chk("no early timeout", timeout, 0);
      chk("still locked", locked, 1);
      while (t_drv < m_prev + 110) step();
      chk("timeout set", timeout, 1);
      chk("unlocked on timeout", locked, 0);
      chk("period held", period, last_exp.p);
      chk("high held", high_time, last_exp.h);

      wave(5, 5, 6);
      chk("timeout cleared", timeout, 0);

      wave(50, 50, 1);
      wave(50, 51, 1);
      wave(5, 5, 6);

      set_sig(1'b1);
      repeat (4) step();
      chk("queue empty pre-reset", exp_q.size(), 0);
      rst = 1'b1;
      repeat (3) step();
      chk_zero("mid reset");
      rst = 1'b0;
      m_reset();
      step();
      wave(5, 5, 4);

`ifdef PERIOD_METER_AVG_EN
      set_sig(1'b0);
      repeat (120) step();
      wave(4, 4, 1);
      wave(6, 6, 1);
      wave(4, 4, 1);
      wave(6, 6, 1);
      wave(8, 8, 1);
      chk("avg period", obs_p, 10);
      chk("avg high", obs_h, 5);
      set_sig(1'b1);
      repeat (5) step();
      chk("avg period 5th", obs_p, 12);
      set_sig(1'b0);
      step();
`endif

      repeat (40) wave($urandom_range(1, 12), $urandom_range(1, 12), 1);
      repeat (12) wave($urandom_range(1, 60), $urandom_range(1, 60), 1);
      repeat (20) wave($urandom_range(1, 12), $urandom_range(1, 12), 1);

      repeat (10) step();
      chk("queue drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
